// File: rtl/jp_pkg.sv
// Shared constants, opcodes and FSM state type for the 5/3 lifting engine.
// Imported by jp_lane_alu, jp_lift_process and ram_res.
package jp_pkg;

    localparam int LANES    = 16;
    localparam int SAMPLE_W = 9;
    localparam int FLAG_W   = 5;
    localparam int RES_W    = 10;
    localparam int LANE_W   = 4;
    localparam int CNT_W    = 5;
    localparam int ADDR_W   = 10;

    localparam logic [FLAG_W-1:0] FLG_PRED_SUB = 5'd7;
    localparam logic [FLAG_W-1:0] FLG_PRED_ADD = 5'd5;
    localparam logic [FLAG_W-1:0] FLG_UPD_ADD  = 5'd6;
    localparam logic [FLAG_W-1:0] FLG_UPD_SUB  = 5'd4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/jp_lane_alu.sv
// Single-lane 5/3 predict/update computation, purely combinational.
// Ports: i_l/i_s/i_r 9-bit samples, i_code opcode, o_res wrapped 10-bit result.
module jp_lane_alu
    import jp_pkg::*;
(
    input  logic [SAMPLE_W-1:0] i_l,
    input  logic [SAMPLE_W-1:0] i_s,
    input  logic [SAMPLE_W-1:0] i_r,
    input  logic [FLAG_W-1:0]   i_code,
    output logic [RES_W-1:0]    o_res
);

    logic signed [11:0] w_l;
    logic signed [11:0] w_s;
    logic signed [11:0] w_r;
    logic signed [11:0] w_pred;
    logic signed [11:0] w_upd;
    logic signed [11:0] w_res;

    assign w_l = {3'b000, i_l};
    assign w_s = {3'b000, i_s};
    assign w_r = {3'b000, i_r};

    // Operands are non-negative, so logical shifts are exact.
    assign w_pred = (w_l >> 1) + (w_r >> 1);
    assign w_upd  = (w_l + w_r + 12'sd2) >> 2;

    always_comb begin
        w_res = w_s;
        case (i_code)
            FLG_PRED_SUB: w_res = w_s - w_pred;
            FLG_PRED_ADD: w_res = w_s + w_pred;
            FLG_UPD_ADD:  w_res = w_s + w_upd;
            FLG_UPD_SUB:  w_res = w_s - w_upd;
            default:      w_res = w_s;
        endcase
    end

    // Two's-complement wrap to the output width, no saturation.
    assign o_res = w_res[RES_W-1:0];

endmodule

// File: rtl/ram_res.sv
// Result store: 1024 x 10, synchronous write, combinational read.
// Ports: i_clk, i_we, i_waddr, i_wdata, i_raddr, o_rdata (old data on collision).
module ram_res
    import jp_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [RES_W-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [RES_W-1:0]  o_rdata
);

    logic [RES_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/jp_lift_process.sv
// Sixteen-lane 5/3 lifting engine: captures one word, streams 16 lane results.
// Ports: clk_fast, rst (async high), left_s_i/sam_s_i/right_s_i 144b, flgs_s_i 80b,
//   update_s start; res_out_x, res_lane, res_valid, noupdate_s (idle/ready).
// Macro JP_RES_RAM_EN adds an internal result store with res_rd_addr/res_rd_data.
module jp_lift_process
    import jp_pkg::*;
(
    input  logic                       clk_fast,
    input  logic                       rst,
    input  logic [LANES*SAMPLE_W-1:0]  left_s_i,
    input  logic [LANES*SAMPLE_W-1:0]  sam_s_i,
    input  logic [LANES*SAMPLE_W-1:0]  right_s_i,
    input  logic [LANES*FLAG_W-1:0]    flgs_s_i,
    input  logic                       update_s,
`ifdef JP_RES_RAM_EN
    input  logic [ADDR_W-1:0]          res_rd_addr,
    output logic [RES_W-1:0]           res_rd_data,
`endif
    output logic [RES_W-1:0]           res_out_x,
    output logic [LANE_W-1:0]          res_lane,
    output logic                       res_valid,
    output logic                       noupdate_s
);

    state_t r_state;
    state_t w_next;

    logic [LANES*SAMPLE_W-1:0] r_left;
    logic [LANES*SAMPLE_W-1:0] r_sam;
    logic [LANES*SAMPLE_W-1:0] r_right;
    logic [LANES*FLAG_W-1:0]   r_flgs;
    logic [CNT_W-1:0]          r_cnt;

    logic w_capture;
    logic w_emit;
    logic w_done;

    logic [LANE_W-1:0]   w_lane;
    logic [SAMPLE_W-1:0] w_l_arr [LANES];
    logic [SAMPLE_W-1:0] w_s_arr [LANES];
    logic [SAMPLE_W-1:0] w_r_arr [LANES];
    logic [FLAG_W-1:0]   w_c_arr [LANES];
    logic [RES_W-1:0]    w_alu;

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Counter value 16 marks the drain cycle after lane 15 was presented.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_emit    = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (update_s) begin
                    w_capture = 1'b1;
                    w_next    = RUN;
                end
            end
            RUN: begin
                if (r_cnt == CNT_W'(LANES)) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_emit = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_lane = r_cnt[LANE_W-1:0];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_l_arr[k] = r_left[k*SAMPLE_W +: SAMPLE_W];
        assign w_s_arr[k] = r_sam[k*SAMPLE_W +: SAMPLE_W];
        assign w_r_arr[k] = r_right[k*SAMPLE_W +: SAMPLE_W];
        assign w_c_arr[k] = r_flgs[k*FLAG_W +: FLAG_W];
    end

    jp_lane_alu u_alu (
        .i_l    (w_l_arr[w_lane]),
        .i_s    (w_s_arr[w_lane]),
        .i_r    (w_r_arr[w_lane]),
        .i_code (w_c_arr[w_lane]),
        .o_res  (w_alu)
    );

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            r_left     <= '0;
            r_sam      <= '0;
            r_right    <= '0;
            r_flgs     <= '0;
            r_cnt      <= '0;
            res_out_x  <= '0;
            res_lane   <= '0;
            res_valid  <= 1'b0;
            noupdate_s <= 1'b1;
        end else begin
            if (w_capture) begin
                r_left     <= left_s_i;
                r_sam      <= sam_s_i;
                r_right    <= right_s_i;
                r_flgs     <= flgs_s_i;
                r_cnt      <= '0;
                noupdate_s <= 1'b0;
            end
            if (w_emit) begin
                res_out_x <= w_alu;
                res_lane  <= w_lane;
                res_valid <= 1'b1;
                r_cnt     <= r_cnt + 1'b1;
            end
            if (w_done) begin
                res_valid  <= 1'b0;
                noupdate_s <= 1'b1;
            end
        end
    end

`ifdef JP_RES_RAM_EN
    logic [ADDR_W-1:0] res_wr_addr;

    // Address advances with every result written; wraps naturally.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            res_wr_addr <= '0;
        end else if (w_emit) begin
            res_wr_addr <= res_wr_addr + 1'b1;
        end
    end

    ram_res u_ram_res (
        .i_clk   (clk_fast),
        .i_we    (w_emit),
        .i_waddr (res_wr_addr),
        .i_wdata (w_alu),
        .i_raddr (res_rd_addr),
        .o_rdata (res_rd_data)
    );
`endif

endmodule

// File: tb/tb_jp_lift_process.sv
// Randomized self-checking bench for jp_lift_process.
// Reference: per-lane integer arithmetic of the 5/3 lifting rules.
module tb_jp_lift_process;

    logic         clk_fast = 1'b0;
    logic         rst;
    logic [143:0] left_s_i;
    logic [143:0] sam_s_i;
    logic [143:0] right_s_i;
    logic [79:0]  flgs_s_i;
    logic         update_s;
    logic [9:0]   res_out_x;
    logic [3:0]   res_lane;
    logic         res_valid;
    logic         noupdate_s;
`ifdef JP_RES_RAM_EN
    logic [9:0]   res_rd_addr;
    logic [9:0]   res_rd_data;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    int L [16];
    int S [16];
    int R [16];
    int C [16];
    logic [9:0] exp_q [$];

    jp_lift_process dut (
        .clk_fast   (clk_fast),
        .rst        (rst),
        .left_s_i   (left_s_i),
        .sam_s_i    (sam_s_i),
        .right_s_i  (right_s_i),
        .flgs_s_i   (flgs_s_i),
        .update_s   (update_s),
`ifdef JP_RES_RAM_EN
        .res_rd_addr(res_rd_addr),
        .res_rd_data(res_rd_data),
`endif
        .res_out_x  (res_out_x),
        .res_lane   (res_lane),
        .res_valid  (res_valid),
        .noupdate_s (noupdate_s)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [9:0] model(int l, int s, int r, int c);
        int v;
        case (c)
            7:       v = s - (l / 2 + r / 2);
            5:       v = s + (l / 2 + r / 2);
            6:       v = s + (l + r + 2) / 4;
            4:       v = s - (l + r + 2) / 4;
            default: v = s;
        endcase
        return v[9:0];
    endfunction

    task automatic rand_word();
        int codes [4];
        codes = '{7, 5, 6, 4};
        for (int k = 0; k < 16; k++) begin
            L[k] = int'($urandom_range(0, 511));
            S[k] = int'($urandom_range(0, 511));
            R[k] = int'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0)
                C[k] = codes[$urandom_range(0, 3)];
            else
                C[k] = int'($urandom_range(0, 31));
        end
    endtask

    task automatic pack_word();
        for (int k = 0; k < 16; k++) begin
            left_s_i[9*k +: 9]  = L[k][8:0];
            sam_s_i[9*k +: 9]   = S[k][8:0];
            right_s_i[9*k +: 9] = R[k][8:0];
            flgs_s_i[5*k +: 5]  = C[k][4:0];
        end
    endtask

    // Called 1 time unit after a rising edge with the DUT idle.
    task automatic run_word(input string tag);
        logic [9:0] e;
        pack_word();
        update_s = 1'b1;
        @(posedge clk_fast);
        #1;
        update_s = 1'b0;
        rand_inputs_after_capture();
        chk({tag, ":busy_e0"}, noupdate_s, 1'b0);
        chk({tag, ":nvalid_e0"}, res_valid, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk_fast);
            #1;
            e = model(L[k], S[k], R[k], C[k]);
            exp_q.push_back(e);
            chk($sformatf("%s:valid%0d", tag, k), res_valid, 1'b1);
            chk($sformatf("%s:lane%0d", tag, k), res_lane, k[3:0]);
            chk($sformatf("%s:res%0d", tag, k), res_out_x, e);
            chk($sformatf("%s:busy%0d", tag, k), noupdate_s, 1'b0);
        end
        @(posedge clk_fast);
        #1;
        chk({tag, ":valid_e17"}, res_valid, 1'b0);
        chk({tag, ":ready_e17"}, noupdate_s, 1'b1);
        chk({tag, ":lane_hold"}, res_lane, 4'd15);
        chk({tag, ":res_hold"}, res_out_x,
            model(L[15], S[15], R[15], C[15]));
    endtask

    // Inputs are don't-care after capture; scramble them.
    task automatic rand_inputs_after_capture();
        left_s_i  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        sam_s_i   = {$urandom, $urandom, $urandom, $urandom, $urandom};
        right_s_i = {$urandom, $urandom, $urandom, $urandom, $urandom};
        flgs_s_i  = {$urandom, $urandom, $urandom};
    endtask

    task automatic directed(input int code, input string tag);
        rand_word();
        L[0] = 36;
        S[0] = 36;
        R[0] = 44;
        C[0] = code;
        run_word(tag);
    endtask

    initial begin
        int caps [$];
        int nval;
        logic prev;

        rst       = 1'b1;
        update_s  = 1'b0;
        left_s_i  = '0;
        sam_s_i   = '0;
        right_s_i = '0;
        flgs_s_i  = '0;
`ifdef JP_RES_RAM_EN
        res_rd_addr = '0;
`endif
        #1;
        chk("rst_ready", noupdate_s, 1'b1);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_res", res_out_x, 10'd0);
        chk("rst_lane", res_lane, 4'd0);
        repeat (3) @(posedge clk_fast);
        @(negedge clk_fast);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_fast);
            #1;
            chk("idle_ready", noupdate_s, 1'b1);
            chk("idle_valid", res_valid, 1'b0);
            chk("idle_res", res_out_x, 10'd0);
        end

        directed(7, "pred_sub");
        chk("pred_sub_val", exp_q[0], 10'h3FC);
        directed(5, "pred_add");
        chk("pred_add_val", exp_q[16], 10'd76);

`ifdef JP_RES_RAM_EN
        for (int a = 0; a < 32; a++) begin
            res_rd_addr = a[9:0];
            #1;
            chk($sformatf("ram%0d", a), res_rd_data, exp_q[a]);
        end
`endif

        directed(6, "upd_add");
        chk("upd_add_val", exp_q[32], 10'd56);
        directed(4, "upd_sub");
        chk("upd_sub_val", exp_q[48], 10'd16);
        directed(0, "pass");
        chk("pass_val", exp_q[64], 10'd36);

        for (int k = 0; k < 16; k++) begin
            L[k] = 511;
            S[k] = 511;
            R[k] = 511;
            C[k] = 5;
        end
        run_word("max");
        chk("max_wrap", exp_q[80], 10'h3FD);

        for (int w = 0; w < 12; w++) begin
            rand_word();
            run_word($sformatf("rnd%0d", w));
        end

        // Continuous request: captures only at E0 and E18.
        rand_word();
        pack_word();
        update_s = 1'b1;
        prev = 1'b1;
        nval = 0;
        for (int c = 0; c < 36; c++) begin
            @(posedge clk_fast);
            #1;
            if (prev && !noupdate_s) caps.push_back(c);
            prev = noupdate_s;
            if (res_valid) nval++;
        end
        update_s = 1'b0;
        chk("hold_ncap", caps.size(), 2);
        if (caps.size() == 2) begin
            chk("hold_cap0", caps[0], 0);
            chk("hold_cap1", caps[1], 18);
        end
        chk("hold_nvalid", nval, 32);
        @(posedge clk_fast);
        #1;
        chk("hold_idle", noupdate_s, 1'b1);

        // Reset mid-word at E8.
        rand_word();
        pack_word();
        update_s = 1'b1;
        @(posedge clk_fast);
        #1;
        update_s = 1'b0;
        repeat (8) @(posedge clk_fast);
        #2;
        chk("abort_pre_valid", res_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_valid", res_valid, 1'b0);
        chk("abort_ready", noupdate_s, 1'b1);
        chk("abort_res", res_out_x, 10'd0);
        chk("abort_lane", res_lane, 4'd0);
        @(negedge clk_fast);
        rst = 1'b0;
        nval = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk_fast);
            #1;
            if (res_valid) nval++;
        end
        chk("abort_novalid", nval, 0);
        chk("abort_idle", noupdate_s, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jp_lift_process.md
# jp_lift_process

Sixteen-lane JPEG-2000 5/3 lifting engine for the parallel JPEG datapath. It captures one 144-bit word each of left-neighbour, centre and right-neighbour samples plus an 80-bit flag word. It then computes one predict/update result per lane and streams the 16 signed 10-bit results out, one lane per clock. It sits between the sample RAMs (`ram`) and the result store (`ram_res`).

## Interface
- Parameters: none; all widths come from package constants.
- `clk_fast`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `left_s_i`  in  144  left samples: 16 lanes × 9-bit unsigned; lane k = bits [9k+8:9k].
- `sam_s_i`  in  144  centre samples, same lane layout.
- `right_s_i`  in  144  right samples, same lane layout.
- `flgs_s_i`  in  80  16 lanes × 5-bit operation code; lane k = bits [5k+4:5k].
- `update_s`  in  1  start request, level-sampled on the clock edge.
- `res_out_x`  out  10  signed result of the lane named by `res_lane`.
- `res_lane`  out  4  lane index of `res_out_x`.
- `res_valid`  out  1  high while `res_out_x` holds a result.
- `noupdate_s`  out  1  high = idle/ready; low while a word is being processed.

## Operation
- Two states: IDLE and RUN.
- In IDLE with `update_s`=1 at a clock edge:
  - register all four input buses;
  - clear the lane counter;
  - go to RUN; `noupdate_s` goes low.
- Lane operation, with L/S/R = 9-bit lane samples zero-extended to 12-bit signed:
  - code 7: S − ((L>>1) + (R>>1))  (predict, subtract)
  - code 5: S + ((L>>1) + (R>>1))  (predict, add)
  - code 6: S + ((L+R+2)>>2)  (update, add)
  - code 4: S − ((L+R+2)>>2)  (update, subtract)
  - any other code: S (pass-through).
- Shifts are logical on non-negative values.
- The 12-bit result is truncated to its low 10 bits (two's-complement wrap, no saturation).
- `update_s` is ignored in RUN; inputs are don't-care after capture.

## Timing
- Reset values (immediate on `rst`, asynchronous):
  - `res_out_x`=0, `res_lane`=0, `res_valid`=0, `noupdate_s`=1;
  - state IDLE; captured registers cleared.
- Capture edge E0. At edges E1..E16, registered outputs present lane 0..15 with `res_valid`=1; `res_lane`=k at edge Ek+1.
- At E17: `res_valid`=0, `noupdate_s`=1, state IDLE. `res_out_x`/`res_lane` hold their last values.
- Earliest next capture is E18, so one word takes 18 cycles.
- An `update_s` pulse shorter than a clock period that misses an edge is lost.
- `rst` asserted mid-RUN aborts the word; no further results are emitted.

## Configuration
- `JP_RES_RAM_EN` defined: the block instantiates an internal result store (1024 × 10).
  - Each valid result is written at `res_wr_addr`, a 10-bit counter: reset 0, +1 per write, wraps 1023→0.
  - Extra ports: `res_rd_addr` in 10 and `res_rd_data` out 10. Read is combinational; write is synchronous on `clk_fast`.
  - A read of the address being written returns the old data.
- Undefined: no store, no extra ports; results are available only on `res_out_x`.

## Structure
- Package `jp_pkg`:
  - LANES=16, SAMPLE_W=9, FLAG_W=5, RES_W=10;
  - flag constants FLG_PRED_SUB=7, FLG_PRED_ADD=5, FLG_UPD_ADD=6, FLG_UPD_SUB=4;
  - state enum {IDLE, RUN}.
- Sub-module `jp_lane_alu`: purely combinational single-lane computation (L, S, R, code → 10-bit result), fed by a lane mux driven by the counter.
- The result store reuses the existing `ram_res` module.

## Test plan
All arithmetic cases use lane 0 with L=36, S=36, R=44.
- Reset with `update_s`=0 → `noupdate_s`=1, `res_valid`=0, `res_out_x`=0 throughout.
- Predict cases: code 7 → −4 (0x3FC); code 5 → 76. Each appears at E1 with `res_lane`=0.
- Update and default cases: code 6 → 56; code 4 → 16; code 0 → 36.
- All lanes S=L=R=511 with code 5 → every lane gives 1021, wrapped to −3 (0x3FD). `res_valid` high for exactly 16 cycles with lanes 0..15 in order; `noupdate_s` is low from E0 to E17.
- `update_s` held high continuously → captures at E0 and E18 only. Assert `rst` at E8 → outputs return to reset values immediately and no further `res_valid`.
- With `JP_RES_RAM_EN`, after two words, `res_rd_addr`=0..31 returns the 32 results in order.
